// File: rtl/seq_signed_divider.sv
// seq_signed_divider: sequential two's-complement restoring divider with start/busy/done handshake.
// Optional DIV_STATUS_FLAGS_EN adds registered div_by_zero / overflow status outputs.
`default_nettype none

module seq_signed_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_STATUS_FLAGS_EN
  ,
  output logic             div_by_zero,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag_q;
  logic [WIDTH-1:0] dend_q;
  logic             dvs_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
`ifdef DIV_STATUS_FLAGS_EN
  logic             dbz_q;
  logic             ovf_q;
`endif

  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] dend_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic             dvs_zero_d;
  logic             ovf_d;

  always_comb begin
    dend_mag_d = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag_d  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    // Remainder is one bit wider so the trial-subtraction sign is never lost.
    shift_d    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial_d    = shift_d - {1'b0, dvs_mag_q};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shift_d;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    dvs_zero_d = (dvs_mag_q == '0);
    ovf_d      = (dend_q == MOST_NEG) && dvs_neg_q && (dvs_mag_q == {{(WIDTH-1){1'b0}}, 1'b1});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      dend_q      <= '0;
      dvs_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_STATUS_FLAGS_EN
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dend_q    <= dividend;
            dvs_neg_q <= divisor[WIDTH-1];
            dvs_mag_q <= dvs_mag_d;
            quo_q     <= dend_mag_d;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH-1);
            busy_q    <= 1'b1;
            state_q   <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          // The natural restoring result already wraps correctly for MOST_NEG / -1.
          if (dvs_zero_d) begin
            quotient_q  <= '1;
            remainder_q <= dend_q;
          end else begin
            quotient_q  <= (dend_q[WIDTH-1] ^ dvs_neg_q) ? (~quo_q + 1'b1) : quo_q;
            remainder_q <= dend_q[WIDTH-1] ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          end
`ifdef DIV_STATUS_FLAGS_EN
          dbz_q <= dvs_zero_d;
          ovf_q <= ovf_d;
`endif
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_STATUS_FLAGS_EN
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed self-checking bench for seq_signed_divider (WIDTH=4).
`default_nettype none

module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_STATUS_FLAGS_EN
  logic       div_by_zero;
  logic       overflow;
`endif

  int tests = 0;
  int fails = 0;

  seq_signed_divider #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_STATUS_FLAGS_EN
    ,
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from request to done; optional second start injected at E2.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_q, input logic [3:0] exp_r,
                        input logic exp_dz, input logic exp_ov, input bit inject);
    int busy_cnt;
    int done_cnt;
    int lat;
    busy_cnt = 0;
    done_cnt = 0;
    lat      = -1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (inject && k == 1) begin
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
      end
      if (inject && k == 2) start = 1'b0;
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_busy_cycles"}, busy_cnt, 5);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_remainder"}, remainder, exp_r);
`ifdef DIV_STATUS_FLAGS_EN
    check({tag, "_div_by_zero"}, div_by_zero, exp_dz);
    check({tag, "_overflow"}, overflow, exp_ov);
`else
    if (exp_dz && exp_ov) $display("[TB] note: %s flags not built", tag);
`endif
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    busy_seen = 0;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("reset_busy", busy_seen, 0);
    check("reset_done", done_seen, 0);
    check("reset_quotient", quotient, 4'h0);
    check("reset_remainder", remainder, 4'h0);
`ifdef DIV_STATUS_FLAGS_EN
    check("reset_div_by_zero", div_by_zero, 1'b0);
    check("reset_overflow", overflow, 1'b0);
`endif

    run_op("p7_p2", 4'd7, 4'd2, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op("m7_p2", 4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0);
    run_op("p7_m2", 4'd7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op("div0",  4'd5, 4'd0, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
    run_op("ovf",   4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0);
    run_op("busy_start", 4'd6, 4'd3, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1);

    // Abort mid-operation with reset.
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 4'h0);
    check("abort_remainder", remainder, 4'h0);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_stays_idle", busy_seen, 0);

    run_op("p6_p4", 4'd6, 4'd4, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed (two's complement) restoring divider, WIDTH-bit operands; the division counterpart of the Booth multiplier datapath.
- Self-contained: internal FSM, iteration counter, partial-remainder and quotient shift registers.
- Start/busy/done handshake toward the top-level controller; results held in output registers until the next accepted start.

Parameters:
WIDTH, 4, operand/result width in bits (minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed dividend, captured on the accepting edge
divisor  input  WIDTH  signed divisor, captured on the accepting edge
busy  output  1  high while the operation is in progress (DIV, FIX)
done  output  1  single-cycle pulse; results valid
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign of the dividend

Behaviour:
- Reset (rst=0, async, any state): state=IDLE; counter, internal registers, quotient, remainder, busy, done, and flags (if present) all 0.
- FSM states: IDLE, DIV, FIX, DONE.
- IDLE
  - start=1 at an edge: capture dividend/divisor, their magnitudes, and the sign bits; counter=WIDTH-1; go to DIV.
  - Otherwise stay in IDLE.
- DIV
  - One restoring step per cycle: shift {partial remainder, quotient magnitude} left 1; trial-subtract |divisor| at WIDTH+1 bits.
  - Non-negative trial: keep it and set quotient LSB=1. Negative: restore and set quotient LSB=0.
  - After WIDTH steps (counter reaches 0), go to FIX.
- FIX (one cycle), sign correction, registered into quotient/remainder:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; busy=0; unconditionally return to IDLE on the next edge.
- Latency:
  - Capture edge = E0; DIV occupies E1..E_WIDTH; FIX result registered at E_WIDTH+1.
  - done is high in the cycle after E_WIDTH+1. For WIDTH=4, that is 5 edges after capture.
- busy: high from E0 until E_WIDTH+1.
- start while busy or in DONE: ignored, with no queuing. Inputs may change freely after E0.
- Outputs quotient/remainder are stable from FIX until overwritten by the next operation's FIX; they are not cleared by start.
- Divide by zero (divisor=0):
  - Full latency is preserved.
  - FIX forces quotient = all ones (-1) and remainder = captured dividend.
- Overflow (dividend = most-negative, divisor = -1):
  - quotient = most-negative value (wraps); remainder = 0.
  - Full latency is preserved.
- Reset asserted mid-operation: the operation is aborted immediately and done is not produced. After release, the block stays in IDLE until start.

Optional Feature:
- Macro: DIV_STATUS_FLAGS_EN.
- Defined: two extra output ports.
  - div_by_zero (1 bit): set in FIX when the captured divisor is 0.
  - overflow (1 bit): set in FIX when dividend = most-negative and divisor = -1.
  - Both are registered alongside the results and held until the next FIX; both are reset to 0.
- Not defined:
  - The ports are absent.
  - Results, forced values, and timing are identical to the defined case.

Test Plan:
- After reset, hold start=0 for 10 cycles -> busy=0, done=0, quotient=4'h0, remainder=4'h0.
- dividend=7, divisor=2, start 1 cycle -> done 5 edges later; quotient=4'h3, remainder=4'h1; busy high for exactly 5 cycles.
- dividend=-7 (4'h9), divisor=2 -> quotient=4'hD (-3), remainder=4'hF (-1). dividend=7, divisor=-2 (4'hE) -> quotient=4'hD, remainder=4'h1.
- dividend=5, divisor=0 -> quotient=4'hF, remainder=4'h5, same latency; div_by_zero=1 with DIV_STATUS_FLAGS_EN. Then dividend=-8 (4'h8), divisor=-1 (4'hF) -> quotient=4'h8, remainder=4'h0, overflow=1, div_by_zero=0.
- start with 6/3, then pulse start with 1/1 on E2 -> the second request is ignored; quotient=4'h2, remainder=4'h0; a single done pulse.
- start 6/4, drive rst=0 at E2 -> outputs immediately 0, no done. Release rst, start 6/4 -> quotient=4'h1, remainder=4'h2.
